// File: rtl/id_ex_hazard_stage.sv
// ID/EX control register with load-use stall detection, redirect bubbles
// and saturating stall/flush event counters for debug.
module id_ex_hazard_stage #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           OP_i,
  input  logic [4:0]           Rs1_i,
  input  logic [4:0]           Rs2_i,
  input  logic [4:0]           Rd_i,
  input  logic                 Branch_i,
  input  logic                 Mem_Read_i,
  input  logic                 Mem_to_Reg_i,
  input  logic                 Mem_Write_i,
  input  logic                 ALU_Src_i,
  input  logic                 Reg_Write_i,
  input  logic                 Jal_i,
  input  logic                 Jalr_i,
  input  logic [2:0]           ALU_Op_i,
  input  logic                 Flush_i,
  output logic                 EX_Branch_o,
  output logic                 EX_Mem_Read_o,
  output logic                 EX_Mem_to_Reg_o,
  output logic                 EX_Mem_Write_o,
  output logic                 EX_ALU_Src_o,
  output logic                 EX_Reg_Write_o,
  output logic                 EX_Jal_o,
  output logic                 EX_Jalr_o,
  output logic [2:0]           EX_ALU_Op_o,
  output logic [4:0]           EX_Rd_o,
  output logic                 EX_Valid_o,
  output logic                 PC_Write_o,
  output logic                 IF_ID_Write_o,
  output logic                 IF_ID_Flush_o,
  output logic [CNT_WIDTH-1:0] Stall_Count_o,
  output logic [CNT_WIDTH-1:0] Flush_Count_o
);

  typedef enum logic [6:0] {
    OP_R    = 7'b0110011,
    OP_I    = 7'b0010011,
    OP_U    = 7'b0110111,
    OP_B    = 7'b1100011,
    OP_S    = 7'b0100011,
    OP_LOAD = 7'b0000011,
    OP_JAL  = 7'b1101111,
    OP_JALR = 7'b1100111
  } opcode_e;

  logic use_rs1;
  logic use_rs2;
  logic load_use;
  logic stall;
  logic bubble;

  // Only the source fields the opcode actually reads may create a hazard.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (OP_i)
      OP_R, OP_B, OP_S: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = EX_Valid_o && EX_Mem_Read_o && (EX_Rd_o != 5'd0) &&
                    ((use_rs1 && (Rs1_i == EX_Rd_o)) ||
                     (use_rs2 && (Rs2_i == EX_Rd_o)));

  // A redirect discards the dependent instruction, so it overrides the stall.
  assign stall  = load_use && !Flush_i;
  assign bubble = stall || Flush_i;

  assign PC_Write_o    = !stall;
  assign IF_ID_Write_o = !stall;
  assign IF_ID_Flush_o = Flush_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      EX_Branch_o     <= 1'b0;
      EX_Mem_Read_o   <= 1'b0;
      EX_Mem_to_Reg_o <= 1'b0;
      EX_Mem_Write_o  <= 1'b0;
      EX_ALU_Src_o    <= 1'b0;
      EX_Reg_Write_o  <= 1'b0;
      EX_Jal_o        <= 1'b0;
      EX_Jalr_o       <= 1'b0;
      EX_ALU_Op_o     <= '0;
      EX_Rd_o         <= '0;
      EX_Valid_o      <= 1'b0;
      Stall_Count_o   <= '0;
      Flush_Count_o   <= '0;
    end else begin
      if (bubble) begin
        EX_Branch_o     <= 1'b0;
        EX_Mem_Read_o   <= 1'b0;
        EX_Mem_to_Reg_o <= 1'b0;
        EX_Mem_Write_o  <= 1'b0;
        EX_ALU_Src_o    <= 1'b0;
        EX_Reg_Write_o  <= 1'b0;
        EX_Jal_o        <= 1'b0;
        EX_Jalr_o       <= 1'b0;
        EX_ALU_Op_o     <= '0;
        EX_Rd_o         <= '0;
        EX_Valid_o      <= 1'b0;
      end else begin
        EX_Branch_o     <= Branch_i;
        EX_Mem_Read_o   <= Mem_Read_i;
        EX_Mem_to_Reg_o <= Mem_to_Reg_i;
        EX_Mem_Write_o  <= Mem_Write_i;
        EX_ALU_Src_o    <= ALU_Src_i;
        EX_Reg_Write_o  <= Reg_Write_i;
        EX_Jal_o        <= Jal_i;
        EX_Jalr_o       <= Jalr_i;
        EX_ALU_Op_o     <= ALU_Op_i;
        EX_Rd_o         <= Rd_i;
        EX_Valid_o      <= 1'b1;
      end
      if (stall && (Stall_Count_o != '1))
        Stall_Count_o <= Stall_Count_o + CNT_WIDTH'(1);
      if (Flush_i && (Flush_Count_o != '1))
        Flush_Count_o <= Flush_Count_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage: directed vectors push expected
// snapshots, a monitor pops and compares them against the DUT.
module tb_id_ex_hazard_stage;
  localparam int unsigned CW = 2;

  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPU = 7'b0110111;
  localparam logic [6:0] OPB = 7'b1100011, OPS = 7'b0100011, OPL = 7'b0000011;
  localparam logic [6:0] OPJ = 7'b1101111, OPJR = 7'b1100111, NOP = 7'b0000000;
  // control bundle order: {Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, Jal, Jalr}
  localparam logic [7:0] C_LD = 8'b01101100, C_R = 8'b00000100, C_S = 8'b00011000;
  localparam logic [7:0] C_I = 8'b00001100, C_J = 8'b00000110, C_B = 8'b10000000;
  localparam logic [7:0] C_JR = 8'b00000101, C_0 = 8'b00000000;

  logic clk, reset;
  logic [6:0] OP_i;
  logic [4:0] Rs1_i, Rs2_i, Rd_i;
  logic Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i, Jal_i, Jalr_i;
  logic [2:0] ALU_Op_i;
  logic Flush_i;
  logic EX_Branch_o, EX_Mem_Read_o, EX_Mem_to_Reg_o, EX_Mem_Write_o;
  logic EX_ALU_Src_o, EX_Reg_Write_o, EX_Jal_o, EX_Jalr_o;
  logic [2:0] EX_ALU_Op_o;
  logic [4:0] EX_Rd_o;
  logic EX_Valid_o, PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o;
  logic [CW-1:0] Stall_Count_o, Flush_Count_o;

  id_ex_hazard_stage #(.CNT_WIDTH(CW)) u_dut (
    .clk(clk), .reset(reset), .OP_i(OP_i), .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Rd_i(Rd_i),
    .Branch_i(Branch_i), .Mem_Read_i(Mem_Read_i), .Mem_to_Reg_i(Mem_to_Reg_i),
    .Mem_Write_i(Mem_Write_i), .ALU_Src_i(ALU_Src_i), .Reg_Write_i(Reg_Write_i),
    .Jal_i(Jal_i), .Jalr_i(Jalr_i), .ALU_Op_i(ALU_Op_i), .Flush_i(Flush_i),
    .EX_Branch_o(EX_Branch_o), .EX_Mem_Read_o(EX_Mem_Read_o),
    .EX_Mem_to_Reg_o(EX_Mem_to_Reg_o), .EX_Mem_Write_o(EX_Mem_Write_o),
    .EX_ALU_Src_o(EX_ALU_Src_o), .EX_Reg_Write_o(EX_Reg_Write_o),
    .EX_Jal_o(EX_Jal_o), .EX_Jalr_o(EX_Jalr_o), .EX_ALU_Op_o(EX_ALU_Op_o),
    .EX_Rd_o(EX_Rd_o), .EX_Valid_o(EX_Valid_o), .PC_Write_o(PC_Write_o),
    .IF_ID_Write_o(IF_ID_Write_o), .IF_ID_Flush_o(IF_ID_Flush_o),
    .Stall_Count_o(Stall_Count_o), .Flush_Count_o(Flush_Count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] v;
  } rec_t;

  rec_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  event mon_now;

  logic [7:0]    m_ctl;
  logic [2:0]    m_alu;
  logic [4:0]    m_rd;
  logic          m_valid;
  logic [CW-1:0] m_sc, m_fc;

  // Snapshot layout: {PC_Write, IF_ID_Write, IF_ID_Flush, ctl[7:0], alu, rd, valid, stall_cnt, flush_cnt}
  rec_t        mr;
  logic [23:0] act;
  always @(negedge clk or mon_now) begin
    if (q.size() > 0) begin
      mr  = q.pop_front();
      act = {PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o,
             EX_Branch_o, EX_Mem_Read_o, EX_Mem_to_Reg_o, EX_Mem_Write_o,
             EX_ALU_Src_o, EX_Reg_Write_o, EX_Jal_o, EX_Jalr_o,
             EX_ALU_Op_o, EX_Rd_o, EX_Valid_o, Stall_Count_o, Flush_Count_o};
      n_tests++;
      if (act !== mr.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", mr.name, act, mr.v);
      end
    end
  end

  task automatic set_in(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [7:0] ctl, input logic [2:0] alu,
                        input logic flush);
    OP_i = op; Rs1_i = rs1; Rs2_i = rs2; Rd_i = rd;
    {Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i, Jal_i, Jalr_i} = ctl;
    ALU_Op_i = alu; Flush_i = flush;
  endtask

  task automatic push(input string name, input logic exp_stall);
    rec_t r;
    r.name = name;
    r.v = {~exp_stall, ~exp_stall, Flush_i, m_ctl, m_alu, m_rd, m_valid, m_sc, m_fc};
    q.push_back(r);
  endtask

  // exp_stall is the hand-derived hazard decision for this ID instruction.
  task automatic drive(input string name, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctl,
                       input logic [2:0] alu, input logic flush, input logic exp_stall);
    @(posedge clk); #1;
    set_in(op, rs1, rs2, rd, ctl, alu, flush);
    push(name, exp_stall);
    if (exp_stall || flush) begin
      m_ctl = '0; m_alu = '0; m_rd = '0; m_valid = 1'b0;
    end else begin
      m_ctl = ctl; m_alu = alu; m_rd = rd; m_valid = 1'b1;
    end
    if (exp_stall && (m_sc != '1)) m_sc = m_sc + 1'b1;
    if (flush && (m_fc != '1)) m_fc = m_fc + 1'b1;
  endtask

  // Called with reset already low: check state immediately, then release
  // with a nop held so the release edge captures a valid all-zero bundle.
  task automatic finish_reset(input string name);
    #1;
    m_ctl = '0; m_alu = '0; m_rd = '0; m_valid = 1'b0; m_sc = '0; m_fc = '0;
    push(name, 1'b0);
    ->mon_now;
    @(posedge clk); #1;
    set_in(NOP, 5'd0, 5'd0, 5'd0, C_0, 3'd0, 1'b0);
    reset = 1'b1;
    m_valid = 1'b1;
  endtask

  task automatic reset_mid(input string name);
    #6 reset = 1'b0;
    finish_reset(name);
  endtask

  initial begin
    reset = 1'b0;
    set_in(NOP, 5'd0, 5'd0, 5'd0, C_0, 3'd0, 1'b0);
    finish_reset("reset_init");

    // async reset while a stall is active
    drive("t1_load",      OPL, 5'd1, 5'd0, 5'd5, C_LD, 3'd0, 1'b0, 1'b0);
    drive("t1_stall",     OPR, 5'd5, 5'd6, 5'd8, C_R,  3'd2, 1'b0, 1'b1);
    reset_mid("t1_reset_mid_stall");

    // load-use coincident with a redirect
    drive("t5_load",      OPL, 5'd1, 5'd0, 5'd5, C_LD, 3'd0, 1'b0, 1'b0);
    drive("t5_flush",     OPR, 5'd5, 5'd6, 5'd8, C_R,  3'd2, 1'b1, 1'b0);
    drive("t5_bubble",    NOP, 5'd0, 5'd0, 5'd0, C_0,  3'd0, 1'b0, 1'b0);

    // classic one-cycle load-use stall
    drive("t2_load",      OPL, 5'd1, 5'd0, 5'd5, C_LD, 3'd0, 1'b0, 1'b0);
    drive("t2_stall",     OPR, 5'd5, 5'd6, 5'd8, C_R,  3'd2, 1'b0, 1'b1);
    drive("t2_retry",     OPR, 5'd5, 5'd6, 5'd8, C_R,  3'd2, 1'b0, 1'b0);
    drive("t2_r_in_ex",   NOP, 5'd0, 5'd0, 5'd0, C_0,  3'd0, 1'b0, 1'b0);

    // rd = x0 never stalls
    drive("t3_load_x0",   OPL, 5'd1, 5'd0, 5'd0, C_LD, 3'd0, 1'b0, 1'b0);
    drive("t3_r_x0",      OPR, 5'd0, 5'd0, 5'd9, C_R,  3'd2, 1'b0, 1'b0);
    drive("t3_done",      NOP, 5'd0, 5'd0, 5'd0, C_0,  3'd0, 1'b0, 1'b0);

    // unused rs2 field vs real rs2 use
    drive("t4_load7",     OPL, 5'd1, 5'd0, 5'd7, C_LD, 3'd0, 1'b0, 1'b0);
    drive("t4_i_rs2",     OPI, 5'd3, 5'd7, 5'd10, C_I, 3'd3, 1'b0, 1'b0);
    drive("t4_load7b",    OPL, 5'd1, 5'd0, 5'd7, C_LD, 3'd0, 1'b0, 1'b0);
    drive("t4_s_stall",   OPS, 5'd3, 5'd7, 5'd0, C_S,  3'd0, 1'b0, 1'b1);
    drive("t4_s_retry",   OPS, 5'd3, 5'd7, 5'd0, C_S,  3'd0, 1'b0, 1'b0);

    // back-to-back loads stall once
    drive("bb_load4",     OPL, 5'd4, 5'd0, 5'd4, C_LD, 3'd0, 1'b0, 1'b0);
    drive("bb_load_dep",  OPL, 5'd4, 5'd0, 5'd4, C_LD, 3'd0, 1'b0, 1'b1);
    drive("bb_retry",     OPL, 5'd4, 5'd0, 5'd4, C_LD, 3'd0, 1'b0, 1'b0);
    drive("bb_done",      NOP, 5'd0, 5'd0, 5'd0, C_0,  3'd0, 1'b0, 1'b0);

    // stall counter saturates at 3
    drive("sat_load2",    OPL, 5'd1, 5'd0, 5'd2, C_LD, 3'd0, 1'b0, 1'b0);
    drive("sat_stall",    OPR, 5'd1, 5'd2, 5'd11, C_R, 3'd2, 1'b0, 1'b1);
    drive("sat_retry",    OPR, 5'd1, 5'd2, 5'd11, C_R, 3'd2, 1'b0, 1'b0);

    // U/JAL/B/JALR: rs fields ignored where unused, bundles pass through
    drive("u_load3",      OPL, 5'd1, 5'd0, 5'd3, C_LD, 3'd0, 1'b0, 1'b0);
    drive("u_no_use",     OPU, 5'd3, 5'd3, 5'd12, C_R, 3'd5, 1'b0, 1'b0);
    drive("jal_pass",     OPJ, 5'd3, 5'd3, 5'd1, C_J,  3'd7, 1'b0, 1'b0);
    drive("b_pass",       OPB, 5'd0, 5'd0, 5'd0, C_B,  3'd1, 1'b0, 1'b0);
    drive("jalr_pass",    OPJR, 5'd1, 5'd0, 5'd2, C_JR, 3'd6, 1'b0, 1'b0);
    drive("tail",         NOP, 5'd0, 5'd0, 5'd0, C_0,  3'd0, 1'b0, 1'b0);

    // flush counter saturation: 1,2,3,3,3
    reset_mid("t6_reset");
    for (int i = 0; i < 5; i++)
      drive($sformatf("t6_flush%0d", i), NOP, 5'd0, 5'd0, 5'd0, C_0, 3'd0, 1'b1, 1'b0);
    drive("t6_hold_a",    NOP, 5'd0, 5'd0, 5'd0, C_0,  3'd0, 1'b0, 1'b0);
    drive("t6_hold_b",    NOP, 5'd0, 5'd0, 5'd0, C_0,  3'd0, 1'b0, 1'b0);

    @(negedge clk); #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- Downstream neighbour of the main decoder in the 5-stage RISC-V pipeline.
- Holds the ID/EX control register: it latches the decoder's control bundle and the destination register into the EX stage each cycle.
- Detects load-use hazards and stalls PC and IF/ID for one cycle while inserting a bubble.
- Converts an EX-stage redirect (taken branch, JAL, JALR) into a bubble plus an IF/ID flush, and keeps saturating stall/flush event counters for debug.

Parameters:
CNT_WIDTH, 16, width of each saturating event counter

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
OP_i  input  7  opcode of the instruction in ID
Rs1_i  input  5  rs1 field of the ID instruction
Rs2_i  input  5  rs2 field of the ID instruction
Rd_i  input  5  rd field of the ID instruction
Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i, Jal_i, Jalr_i  input  1 each  decoder control bits
ALU_Op_i  input  3  decoder ALU operation class
Flush_i  input  1  EX-stage redirect this cycle
EX_Branch_o, EX_Mem_Read_o, EX_Mem_to_Reg_o, EX_Mem_Write_o, EX_ALU_Src_o, EX_Reg_Write_o, EX_Jal_o, EX_Jalr_o  output  1 each  registered control bits in EX
EX_ALU_Op_o  output  3  registered ALU operation class
EX_Rd_o  output  5  registered rd
EX_Valid_o  output  1  EX holds a real instruction, not a bubble
PC_Write_o  output  1  PC update enable
IF_ID_Write_o  output  1  IF/ID register load enable
IF_ID_Flush_o  output  1  IF/ID clear request
Stall_Count_o  output  CNT_WIDTH  stall cycles, saturating
Flush_Count_o  output  CNT_WIDTH  flush cycles, saturating

Behaviour:
- Reset (reset=0, asynchronous, effective immediately, including mid-stall): all EX_* outputs 0, EX_Valid_o 0, both counters 0.
- Opcode encodings used below:
  - R = 0110011, I_logic = 0010011, U = 0110111, B = 1100011
  - S = 0100011, Load = 0000011, JAL = 1101111, JALR = 1100111
- use_rs1 = OP_i in {R, I_logic, B, S, Load, JALR}.
- use_rs2 = OP_i in {R, B, S}.
- Unknown opcodes: use_rs1 = use_rs2 = 0.
- load_use (combinational):
  - requires EX_Valid_o & EX_Mem_Read_o & (EX_Rd_o != 0)
  - and ((use_rs1 & Rs1_i == EX_Rd_o) | (use_rs2 & Rs2_i == EX_Rd_o)).
- stall = load_use & ~Flush_i. A flush takes precedence over a stall, because the dependent instruction is discarded anyway.
- Combinational outputs:
  - PC_Write_o = ~stall
  - IF_ID_Write_o = ~stall
  - IF_ID_Flush_o = Flush_i
  - Zero-latency, same cycle.
- Rising clk, when stall | Flush_i: load a bubble, i.e. all EX control bits 0, EX_ALU_Op_o 0, EX_Rd_o 0, EX_Valid_o 0.
- Rising clk, otherwise: capture all *_i controls and Rd_i, set EX_Valid_o 1. Latency from ID to EX outputs is 1 cycle.
- A stall lasts exactly 1 cycle: the inserted bubble clears EX_Mem_Read_o, so the same ID instruction proceeds on the next edge. Back-to-back loads each stall at most once.
- Stall_Count_o increments by 1 on each edge where stall=1.
- Flush_Count_o increments by 1 on each edge where Flush_i=1.
- Both counters hold at all-ones and do not wrap.
- rd = x0 never causes a stall.
- A load into a register the ID instruction does not read (e.g. rs2 field of I_logic, U, JAL) does not stall.

Test Plan:
1. Assert reset low mid-run with EX_Valid_o=1 and a stall active -> all outputs zero at once, PC_Write_o=1, counters 0.
2. Load rd=5 enters EX, ID holds R-type with rs1=5 -> PC_Write_o=IF_ID_Write_o=0 for 1 cycle, bubble in EX (EX_Valid_o=0), R-type in EX one cycle later, Stall_Count_o=1.
3. Load rd=0 followed by R-type rs1=0, rs2=0 -> no stall, Stall_Count_o stays 0.
4. Load rd=7 followed by I_logic whose rs2 field=7, rs1=3 -> no stall. Same with S-type rs2=7 -> stall 1 cycle.
5. Load-use hazard coincident with Flush_i=1 -> PC_Write_o=1, IF_ID_Flush_o=1, bubble next cycle, Flush_Count_o=1, Stall_Count_o=0.
6. CNT_WIDTH=2, five consecutive flush cycles -> Flush_Count_o sequence 1,2,3,3,3.
